// File: rtl/sub_result_stage.sv
// Registered output stage behind the N-bit subtractor: captures DIFF/BORROW,
// derives zero/negative/overflow flags at capture time, optionally clamps an
// unsigned underflow to zero, buffers results in a 2-entry skid buffer and
// keeps a saturating count of accepted borrow results.
module sub_result_stage #(
  parameter int N            = 8,
  parameter int SAT_UNSIGNED = 0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_diff,
  input  logic             in_borrow,
  input  logic             in_a_msb,
  input  logic             in_b_msb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_diff,
  output logic             out_borrow,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic [CNT_W-1:0] borrow_cnt,
  input  logic             cnt_clr
);

  typedef struct packed {
    logic [N-1:0] diff;
    logic         borrow;
    logic         zero;
    logic         neg;
    logic         ovf;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state_reg, state_next;
  entry_t           head_reg, head_next;
  entry_t           skid_reg, skid_next;
  entry_t           in_entry;
  logic             in_ready_reg, in_ready_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             push;
  logic             pop;

  assign in_ready   = in_ready_reg;
  assign out_valid  = (state_reg != EMPTY);
  assign push       = in_valid & in_ready_reg;
  assign pop        = out_valid & out_ready;

  // Head entry drives the outputs directly, so they hold while stalled.
  assign out_diff   = head_reg.diff;
  assign out_borrow = head_reg.borrow;
  assign out_zero   = head_reg.zero;
  assign out_neg    = head_reg.neg;
  assign out_ovf    = head_reg.ovf;
  assign borrow_cnt = cnt_reg;

  // Flags are taken from the raw difference, before any clamping.
  always_comb begin
    in_entry.diff   = ((SAT_UNSIGNED != 0) && in_borrow) ? '0 : in_diff;
    in_entry.borrow = in_borrow;
    in_entry.zero   = (in_diff == '0);
    in_entry.neg    = in_diff[N-1];
    in_entry.ovf    = (in_a_msb ^ in_b_msb) & (in_diff[N-1] ^ in_a_msb);
  end

  // Skid-buffer next-state and entry movement.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          head_next  = in_entry;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_next = FULL;
          skid_next  = in_entry;
        end else if (push && pop) begin
          head_next  = in_entry;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_next = ONE;
          head_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
    // Registered ready: accept again as soon as a slot will be free.
    in_ready_next = (state_next != FULL);
  end

  // Saturating borrow counter; clear wins over a same-cycle increment.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (push && in_borrow && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // State, entries and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= EMPTY;
      head_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      head_reg     <= head_next;
      skid_reg     <= skid_next;
      in_ready_reg <= in_ready_next;
      cnt_reg      <= cnt_next;
    end
  end

endmodule

// File: tb/tb_sub_result_stage.sv
// Testbench for sub_result_stage: table of single-result vectors, then
// back-pressure, random traffic, counter clear and asynchronous reset sequences.
// Two instances share the stimulus: plain (SAT_UNSIGNED=0, CNT_W=16) and
// clamping (SAT_UNSIGNED=1, CNT_W=2).
module tb_sub_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_diff = '0;
  logic       in_borrow = 1'b0;
  logic       in_a_msb = 1'b0;
  logic       in_b_msb = 1'b0;
  logic       out_ready = 1'b0;
  logic       cnt_clr = 1'b0;

  logic        in_ready, out_valid, out_borrow, out_zero, out_neg, out_ovf;
  logic [7:0]  out_diff;
  logic [15:0] borrow_cnt;
  logic        s_in_ready, s_out_valid, s_out_borrow, s_out_zero, s_out_neg, s_out_ovf;
  logic [7:0]  s_out_diff;
  logic [1:0]  s_borrow_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sub_result_stage #(.N(8), .SAT_UNSIGNED(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_diff(in_diff), .in_borrow(in_borrow), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
    .out_borrow(out_borrow), .out_zero(out_zero), .out_neg(out_neg), .out_ovf(out_ovf),
    .borrow_cnt(borrow_cnt), .cnt_clr(cnt_clr));

  sub_result_stage #(.N(8), .SAT_UNSIGNED(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_diff(in_diff), .in_borrow(in_borrow), .in_a_msb(in_a_msb), .in_b_msb(in_b_msb),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_diff(s_out_diff),
    .out_borrow(s_out_borrow), .out_zero(s_out_zero), .out_neg(s_out_neg), .out_ovf(s_out_ovf),
    .borrow_cnt(s_borrow_cnt), .cnt_clr(cnt_clr));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_ab(input logic [7:0] a, input logic [7:0] b);
    in_diff   = a - b;
    in_borrow = (a < b);
    in_a_msb  = a[7];
    in_b_msb  = b[7];
  endtask

  // Expected head-entry contents for the scoreboard.
  typedef struct {
    logic [7:0] diff;
    logic [7:0] sdiff;
    logic       b, z, n, o;
  } exp_t;

  exp_t q[$];
  bit   sb_en = 0;
  int   push_count = 0;
  int   pop_count = 0;
  int   model_cnt = 0;

  // Scoreboard: sampled mid-cycle, pop compares the head before a push enqueues.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      model_cnt = 0;
    end else begin
      if (sb_en && out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_pop", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_result", {out_diff, out_borrow, out_zero, out_neg, out_ovf},
              {e.diff, e.b, e.z, e.n, e.o});
          chk("sb_sat_result", {s_out_diff, s_out_borrow, s_out_zero, s_out_neg, s_out_ovf},
              {e.sdiff, e.b, e.z, e.n, e.o});
          pop_count++;
        end
      end
      if (sb_en && in_valid && in_ready) begin
        e.diff  = in_diff;
        e.sdiff = in_borrow ? 8'h00 : in_diff;
        e.b     = in_borrow;
        e.z     = (in_diff == 8'h00);
        e.n     = in_diff[7];
        e.o     = (in_a_msb != in_b_msb) && (in_diff[7] != in_a_msb);
        q.push_back(e);
        push_count++;
      end
      if (cnt_clr) model_cnt = 0;
      else if (in_valid && in_ready && in_borrow) model_cnt++;
    end
  end

  typedef struct {
    logic [7:0] diff;
    logic       borrow, a_msb, b_msb;
    logic [7:0] exp_diff, exp_sat;
    logic       exp_zero, exp_neg, exp_ovf;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int start, cyc, sat_exp;

    // diff, borrow, a_msb, b_msb | diff, sat diff, zero, neg, ovf
    vecs[0] = '{8'h02, 1'b0, 1'b0, 1'b0, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0}; // 0x05-0x03
    vecs[1] = '{8'hFE, 1'b1, 1'b0, 1'b0, 8'hFE, 8'h00, 1'b0, 1'b1, 1'b0}; // 0x01-0x03
    vecs[2] = '{8'h7F, 1'b0, 1'b1, 1'b0, 8'h7F, 8'h7F, 1'b0, 1'b0, 1'b1}; // 0x80-0x01
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}; // 0x22-0x22
    vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 1'b1}; // 0x00-0x80
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b0}; // 0x10-0x11
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0}; // 0x80-0x80

    // Reset state
    #1 rst = 1'b1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_outputs", {out_diff, out_borrow, out_zero, out_neg, out_ovf}, 0);
    chk("rst_cnt", borrow_cnt, 0);

    // Table vectors: push one, check after one edge, then pop it.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; out_ready = 1'b0;
      in_diff = vecs[i].diff; in_borrow = vecs[i].borrow;
      in_a_msb = vecs[i].a_msb; in_b_msb = vecs[i].b_msb;
      @(posedge clk); #1;
      in_valid = 1'b0; in_diff = 'x; in_borrow = 'x; in_a_msb = 'x; in_b_msb = 'x;
      $display("vec %0d diff=%0h borrow=%0b -> out_diff=%0h sat=%0h z=%0b n=%0b o=%0b",
               i, vecs[i].diff, vecs[i].borrow, out_diff, s_out_diff, out_zero, out_neg, out_ovf);
      chk("vec_valid", out_valid, 1);
      chk("vec_diff", out_diff, vecs[i].exp_diff);
      chk("vec_sat_diff", s_out_diff, vecs[i].exp_sat);
      chk("vec_borrow", {out_borrow, s_out_borrow}, {2{vecs[i].borrow}});
      chk("vec_zero", {out_zero, s_out_zero}, {2{vecs[i].exp_zero}});
      chk("vec_neg", out_neg, vecs[i].exp_neg);
      chk("vec_ovf", out_ovf, vecs[i].exp_ovf);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("vec_popped", out_valid, 0);
    end
    in_diff = '0; in_borrow = 1'b0; in_a_msb = 1'b0; in_b_msb = 1'b0;
    chk("tbl_cnt", borrow_cnt, 3);
    chk("tbl_sat_cnt", s_borrow_cnt, 3);

    // Back-pressure: three back-to-back pushes with out_ready low.
    sb_en = 1; start = pop_count;
    in_valid = 1'b1; set_ab(8'h30, 8'h10);
    @(posedge clk); #1;
    chk("bp_ready_after1", in_ready, 1);
    set_ab(8'h10, 8'h30);
    @(posedge clk); #1;
    chk("bp_ready_after2", in_ready, 0);
    set_ab(8'h81, 8'h02);
    @(posedge clk); #1;
    chk("bp_ready_held", in_ready, 0);
    chk("bp_head_held", out_diff, 8'h20);
    chk("bp_pushes", push_count, 2);
    out_ready = 1'b1;
    cyc = 0;
    while (pop_count - start < 3 && cyc < 20) begin
      @(posedge clk); #1;
      if (push_count == 3) in_valid = 1'b0;
      cyc++;
    end
    chk("bp_all_popped", pop_count - start, 3);
    $display("backpressure pushes=%0d pops=%0d", push_count, pop_count - start);
    @(posedge clk); #1;
    chk("bp_no_extra", out_valid, 0);

    // Clear beats a same-cycle borrow increment.
    set_ab(8'h01, 8'h02); in_valid = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; cnt_clr = 1'b0;
    chk("clr_cnt", borrow_cnt, 0);
    chk("clr_sat_cnt", s_borrow_cnt, 0);
    @(posedge clk); #1;

    // Random traffic against the scoreboard.
    start = push_count; cyc = 0;
    while (push_count - start < 100 && cyc < 2000) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = $urandom_range(1);
      set_ab(8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_pushes", push_count - start, 100);
    in_valid = 1'b0; out_ready = 1'b1; cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_out_valid", out_valid, 0);
    sat_exp = (model_cnt > 3) ? 3 : model_cnt;
    $display("random borrows=%0d cnt=%0d sat_cnt=%0d", model_cnt, borrow_cnt, s_borrow_cnt);
    chk("rand_cnt", borrow_cnt, 32'(model_cnt));
    chk("rand_sat_cnt", s_borrow_cnt, 32'(sat_exp));

    // Asynchronous reset while FULL.
    out_ready = 1'b0; in_valid = 1'b1; set_ab(8'h00, 8'h01);
    @(posedge clk); #1;
    set_ab(8'h00, 8'h02);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_cnt", {s_borrow_cnt, borrow_cnt}, 0);
    chk("arst_outputs", {out_diff, out_borrow, out_zero, out_neg, out_ovf}, 0);
    @(posedge clk); #1 rst = 1'b0;
    in_valid = 1'b1; set_ab(8'h05, 8'h03);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_diff", out_diff, 8'h02);
    chk("post_rst_single", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_alone", out_valid, 0);
    $display("reset sequence done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
